// File: rtl/cacheline_adapter.sv
// cacheline_adapter
// Bridges a cache that moves whole lines (dfp side) to a burst memory that
// moves BEAT_W-bit beats (bmem side). A line read becomes one read command
// followed by BEATS returned beats. A line write becomes BEATS write beats,
// each handshaken with bmem_ready. Every registered output is driven from
// the single FSM process below.
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   dfp_addr     line address from the cache (bits [4:0] ignored)
//   dfp_read     line read request, held until dfp_resp
//   dfp_write    line write request, held until dfp_resp (wins over read)
//   dfp_wdata    line to write, stable while dfp_write is high
//   dfp_rdata    most recently completed read line
//   dfp_resp     one-cycle completion pulse
//   bmem_addr    burst address, line aligned
//   bmem_read    read burst command
//   bmem_write   write beat valid
//   bmem_wdata   write beat data
//   bmem_ready   memory accepts the command / beat this cycle
//   bmem_rdata   read beat data
//   bmem_rvalid  read beat valid
module cacheline_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_DATA,
        RESP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  beat_next;
    logic              last_beat;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] rd_buf;
    logic [LINE_W-1:0] rd_merged;

    // The counter wraps to zero on the final beat so that every state is
    // entered with the counter already at zero.
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign beat_next = last_beat ? '0 : beat_cnt + 1'b1;

    // Read lines are assembled in a private buffer; dfp_rdata is only
    // replaced once the whole line is in, so the cache never sees a
    // half-updated line.
    always_comb begin
        rd_merged = rd_buf;
        rd_merged[int'(beat_cnt) * BEAT_W +: BEAT_W] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            wr_line    <= '0;
            rd_buf     <= '0;
            dfp_rdata  <= '0;
            dfp_resp   <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    dfp_resp <= 1'b0;
                    // Write has priority when both requests are raised.
                    if (dfp_write) begin
                        bmem_addr  <= dfp_addr & ~32'h0000_001F;
                        wr_line    <= dfp_wdata;
                        bmem_wdata <= dfp_wdata[BEAT_W-1:0];
                        bmem_write <= 1'b1;
                        state      <= WR_DATA;
                    end else if (dfp_read) begin
                        bmem_addr <= dfp_addr & ~32'h0000_001F;
                        bmem_read <= 1'b1;
                        state     <= RD_CMD;
                    end
                end

                RD_CMD: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        state     <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (bmem_rvalid) begin
                        rd_buf   <= rd_merged;
                        beat_cnt <= beat_next;
                        if (last_beat) begin
                            dfp_rdata <= rd_merged;
                            dfp_resp  <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end

                // A low bmem_ready leaves beat, data and counter untouched,
                // which is what makes a stall safe for the memory.
                WR_DATA: begin
                    if (bmem_ready) begin
                        beat_cnt <= beat_next;
                        if (last_beat) begin
                            bmem_write <= 1'b0;
                            dfp_resp   <= 1'b1;
                            state      <= RESP;
                        end else begin
                            bmem_wdata <= wr_line[int'(beat_next) * BEAT_W +: BEAT_W];
                        end
                    end
                end

                RESP: begin
                    dfp_resp <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter
// Drives the adapter from both sides: the cache side issues line requests,
// and the bench acts as a burst memory, accepting write beats with
// optional back-pressure and returning read beats with optional gaps.
// Expected beats and lines come from slicing the requested line by beat
// index and from the last completed read line kept by the bench.
module tb_cacheline_adapter;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    int checks = 0;
    int passed = 0;

    logic [BEAT_W-1:0] got_beats[$];
    logic [31:0]       got_addrs[$];
    logic [BEAT_W-1:0] stall_vals[$];
    bit                saw_read;
    bit                saw_write;
    bit                timed_out;
    bit                resp_seen;
    int                resp_gap;
    int                resp_cycle;
    int                cmd_cycle;
    int                cmd_count;
    logic [31:0]       cmd_addr;
    logic              resp_after;
    logic [LINE_W-1:0] model_rdata;
    int                overlap_cycles = 0;

    cacheline_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bmem_read && bmem_write) overlap_cycles++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [BEAT_W-1:0] beat_of(input logic [LINE_W-1:0] line, input int i);
        return BEAT_W'(line >> (i * BEAT_W));
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return (a / 32) * 32;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Called at a negedge; returns at a negedge in IDLE (one cycle after RESP).
    task automatic run_write(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                             input bit also_read, input int stall_beat, input int stall_len,
                             input bit rand_ready, input bit noise);
        int cyc, since_last, stall_left;
        got_beats.delete(); got_addrs.delete(); stall_vals.delete();
        saw_read = 0; timed_out = 0; resp_seen = 0; resp_gap = -1; resp_cycle = -1;
        cyc = 0; since_last = 0; stall_left = stall_len;
        dfp_addr = addr; dfp_wdata = line; dfp_write = 1'b1; dfp_read = also_read;
        bmem_ready = 1'b0;
        while (!resp_seen && !timed_out) begin
            @(negedge clk);
            cyc++; since_last++;
            bmem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bmem_rdata = {$urandom, $urandom};
            if (bmem_read) saw_read = 1;
            if (dfp_resp) begin
                resp_seen = 1; resp_gap = since_last; resp_cycle = cyc;
                dfp_write = 1'b0; dfp_read = 1'b0; bmem_ready = 1'b0;
            end else if (cyc > 200) begin
                timed_out = 1;
            end else begin
                if (bmem_write && got_beats.size() == stall_beat && stall_left > 0) begin
                    bmem_ready = 1'b0; stall_left--; stall_vals.push_back(bmem_wdata);
                end else begin
                    bmem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (bmem_write && bmem_ready) begin
                    got_beats.push_back(bmem_wdata);
                    got_addrs.push_back(bmem_addr);
                    since_last = 0;
                end
            end
        end
        dfp_write = 1'b0; dfp_read = 1'b0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
        @(negedge clk);
        resp_after = dfp_resp;
    endtask

    // Called at a negedge. With abort_after >= 0 it returns at the negedge
    // where that many beats have been delivered, leaving dfp_read high.
    task automatic run_read(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                            input bit rand_gaps, input int cmd_delay, input int abort_after);
        int cyc, since_last, delay, sent;
        bit cmd_done;
        saw_write = 0; timed_out = 0; resp_seen = 0; resp_gap = -1; resp_cycle = -1;
        cmd_cycle = -1; cmd_count = 0; cmd_addr = '0;
        cyc = 0; since_last = 0; delay = cmd_delay; sent = 0; cmd_done = 0;
        dfp_addr = addr; dfp_read = 1'b1; dfp_write = 1'b0;
        bmem_ready = 1'b0; bmem_rvalid = 1'b0;
        while (!resp_seen && !timed_out) begin
            @(negedge clk);
            cyc++; since_last++;
            bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = {$urandom, $urandom};
            if (bmem_write) saw_write = 1;
            if (dfp_resp) begin
                resp_seen = 1; resp_gap = since_last; resp_cycle = cyc; dfp_read = 1'b0;
            end else if (sent == abort_after) begin
                return;
            end else if (cyc > 200) begin
                timed_out = 1;
            end else if (bmem_read) begin
                cmd_count++;
                if (cmd_cycle < 0) begin cmd_cycle = cyc; cmd_addr = bmem_addr; end
                if (delay > 0) delay--;
                else begin bmem_ready = 1'b1; cmd_done = 1; end
            end else if (cmd_done && sent < BEATS && (!rand_gaps || $urandom_range(0, 2) != 0)) begin
                bmem_rvalid = 1'b1; bmem_rdata = beat_of(line, sent); sent++; since_last = 0;
            end
        end
        dfp_read = 1'b0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
        @(negedge clk);
        resp_after = dfp_resp;
    endtask

    task automatic test_reset();
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dfp_resp !== 1'b0) $display("[TB] FAIL reset_resp: got %b expected 0", dfp_resp); else passed++;
        checks++; if (bmem_read !== 1'b0) $display("[TB] FAIL reset_read: got %b expected 0", bmem_read); else passed++;
        checks++; if (bmem_write !== 1'b0) $display("[TB] FAIL reset_write: got %b expected 0", bmem_write); else passed++;
        checks++; if (bmem_addr !== 32'h0) $display("[TB] FAIL reset_addr: got %h expected 0", bmem_addr); else passed++;
        checks++; if (bmem_wdata !== '0) $display("[TB] FAIL reset_wdata: got %h expected 0", bmem_wdata); else passed++;
        checks++; if (dfp_rdata !== '0) $display("[TB] FAIL reset_rdata: got %h expected 0", dfp_rdata); else passed++;
        rst_n = 1'b1;
        model_rdata = '0;
    endtask

    task automatic test_write_directed();
        logic [LINE_W-1:0] line;
        line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        run_write(32'h0000_1020, line, 0, -1, 0, 0, 0);
        checks++; if (resp_seen !== 1'b1) $display("[TB] FAIL wr_resp: got %b expected 1", resp_seen); else passed++;
        checks++; if (got_beats.size() != BEATS) $display("[TB] FAIL wr_count: got %0d expected %0d", got_beats.size(), BEATS); else passed++;
        for (int i = 0; i < BEATS; i++) begin
            checks++;
            if (i >= got_beats.size()) $display("[TB] FAIL wr_beat%0d: got none expected %h", i, beat_of(line, i));
            else if (got_beats[i] !== beat_of(line, i) || got_addrs[i] !== 32'h0000_1020)
                $display("[TB] FAIL wr_beat%0d: got %h@%h expected %h@00001020", i, got_beats[i], got_addrs[i], beat_of(line, i));
            else passed++;
        end
        checks++; if (resp_gap != 1) $display("[TB] FAIL wr_resp_gap: got %0d expected 1", resp_gap); else passed++;
        checks++; if (resp_cycle != BEATS + 1) $display("[TB] FAIL wr_latency: got %0d expected %0d", resp_cycle, BEATS + 1); else passed++;
        checks++; if (resp_after !== 1'b0) $display("[TB] FAIL wr_resp_width: got %b expected 0", resp_after); else passed++;
        checks++; if (saw_read !== 1'b0) $display("[TB] FAIL wr_no_read: got %b expected 0", saw_read); else passed++;
    endtask

    task automatic test_read_directed();
        logic [LINE_W-1:0] line;
        line = {64'h44, 64'h33, 64'h22, 64'h11};
        run_read(32'h0000_1000, line, 1, 2, -1);
        checks++; if (resp_seen !== 1'b1) $display("[TB] FAIL rd_resp: got %b expected 1", resp_seen); else passed++;
        checks++; if (dfp_rdata !== line) $display("[TB] FAIL rd_data: got %h expected %h", dfp_rdata, line); else passed++;
        checks++; if (cmd_addr !== 32'h0000_1000) $display("[TB] FAIL rd_addr: got %h expected 00001000", cmd_addr); else passed++;
        checks++; if (cmd_cycle != 1) $display("[TB] FAIL rd_cmd_cycle: got %0d expected 1", cmd_cycle); else passed++;
        checks++; if (cmd_count != 3) $display("[TB] FAIL rd_cmd_hold: got %0d expected 3", cmd_count); else passed++;
        checks++; if (resp_gap != 1) $display("[TB] FAIL rd_resp_gap: got %0d expected 1", resp_gap); else passed++;
        checks++; if (resp_after !== 1'b0) $display("[TB] FAIL rd_resp_width: got %b expected 0", resp_after); else passed++;
        checks++; if (saw_write !== 1'b0) $display("[TB] FAIL rd_no_write: got %b expected 0", saw_write); else passed++;
        model_rdata = line;
    endtask

    task automatic test_write_stall();
        logic [LINE_W-1:0] line;
        line = rand_line();
        run_write(32'h0000_4000, line, 0, 1, 3, 0, 0);
        checks++; if (got_beats.size() != BEATS) $display("[TB] FAIL stall_count: got %0d expected %0d", got_beats.size(), BEATS); else passed++;
        for (int i = 0; i < BEATS; i++) begin
            checks++;
            if (i >= got_beats.size()) $display("[TB] FAIL stall_beat%0d: got none expected %h", i, beat_of(line, i));
            else if (got_beats[i] !== beat_of(line, i)) $display("[TB] FAIL stall_beat%0d: got %h expected %h", i, got_beats[i], beat_of(line, i));
            else passed++;
        end
        checks++; if (stall_vals.size() != 3) $display("[TB] FAIL stall_cycles: got %0d expected 3", stall_vals.size()); else passed++;
        foreach (stall_vals[i]) begin
            checks++;
            if (stall_vals[i] !== beat_of(line, 1)) $display("[TB] FAIL stall_hold%0d: got %h expected %h", i, stall_vals[i], beat_of(line, 1));
            else passed++;
        end
        checks++; if (dfp_rdata !== model_rdata) $display("[TB] FAIL stall_rdata_hold: got %h expected %h", dfp_rdata, model_rdata); else passed++;
    endtask

    task automatic test_both_high();
        logic [LINE_W-1:0] line;
        line = rand_line();
        run_write(32'h0000_001F, line, 1, -1, 0, 0, 0);
        checks++; if (saw_read !== 1'b0) $display("[TB] FAIL both_no_read: got %b expected 0", saw_read); else passed++;
        checks++; if (got_beats.size() != BEATS) $display("[TB] FAIL both_count: got %0d expected %0d", got_beats.size(), BEATS); else passed++;
        for (int i = 0; i < BEATS; i++) begin
            checks++;
            if (i >= got_beats.size()) $display("[TB] FAIL both_beat%0d: got none expected %h", i, beat_of(line, i));
            else if (got_beats[i] !== beat_of(line, i) || got_addrs[i] !== 32'h0)
                $display("[TB] FAIL both_beat%0d: got %h@%h expected %h@00000000", i, got_beats[i], got_addrs[i], beat_of(line, i));
            else passed++;
        end
    endtask

    task automatic test_spurious_rvalid();
        logic [LINE_W-1:0] line;
        int resp_count;
        resp_count = 0;
        for (int i = 0; i < 4; i++) begin
            bmem_rvalid = 1'b1; bmem_rdata = 64'hFF;
            @(negedge clk);
            if (dfp_resp) resp_count++;
        end
        bmem_rvalid = 1'b0;
        checks++; if (dfp_rdata !== model_rdata) $display("[TB] FAIL spur_rdata: got %h expected %h", dfp_rdata, model_rdata); else passed++;
        checks++; if (resp_count != 0) $display("[TB] FAIL spur_resp: got %0d expected 0", resp_count); else passed++;
        line = rand_line();
        run_read(32'h0000_5560, line, 0, 0, -1);
        checks++; if (dfp_rdata !== line) $display("[TB] FAIL spur_next_read: got %h expected %h", dfp_rdata, line); else passed++;
        model_rdata = line;
    endtask

    task automatic test_reset_mid_read();
        logic [LINE_W-1:0] line;
        int resp_count;
        resp_count = 0;
        line = rand_line();
        run_read(32'h0000_2040, line, 0, 0, 2);
        checks++; if (resp_seen !== 1'b0) $display("[TB] FAIL abort_early_resp: got %b expected 0", resp_seen); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bmem_read !== 1'b0 || bmem_write !== 1'b0 || dfp_resp !== 1'b0)
            $display("[TB] FAIL abort_ctrl: got rd=%b wr=%b resp=%b expected 0 0 0", bmem_read, bmem_write, dfp_resp); else passed++;
        checks++; if (bmem_addr !== 32'h0 || bmem_wdata !== '0)
            $display("[TB] FAIL abort_bmem: got addr=%h wdata=%h expected 0 0", bmem_addr, bmem_wdata); else passed++;
        checks++; if (dfp_rdata !== '0) $display("[TB] FAIL abort_rdata: got %h expected 0", dfp_rdata); else passed++;
        dfp_read = 1'b0; bmem_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (dfp_resp) resp_count++;
        end
        rst_n = 1'b1;
        model_rdata = '0;
        checks++; if (resp_count != 0) $display("[TB] FAIL abort_resp: got %0d expected 0", resp_count); else passed++;
        line = rand_line();
        run_read(32'h0000_3000, line, 1, 1, -1);
        checks++; if (cmd_cycle != 1) $display("[TB] FAIL post_reset_accept: got %0d expected 1", cmd_cycle); else passed++;
        checks++; if (dfp_rdata !== line) $display("[TB] FAIL post_reset_read: got %h expected %h", dfp_rdata, line); else passed++;
        model_rdata = line;
    endtask

    task automatic test_back_to_back();
        logic [LINE_W-1:0] line;
        line = rand_line();
        run_write(32'h0000_7000, line, 0, -1, 0, 0, 0);
        checks++; if (resp_cycle != BEATS + 1) $display("[TB] FAIL b2b_wr1_latency: got %0d expected %0d", resp_cycle, BEATS + 1); else passed++;
        line = rand_line();
        run_read(32'h0000_7020, line, 0, 0, -1);
        checks++; if (resp_cycle != BEATS + 2) $display("[TB] FAIL b2b_rd_latency: got %0d expected %0d", resp_cycle, BEATS + 2); else passed++;
        checks++; if (dfp_rdata !== line) $display("[TB] FAIL b2b_rd_data: got %h expected %h", dfp_rdata, line); else passed++;
        model_rdata = line;
        line = rand_line();
        run_write(32'h0000_7040, line, 0, -1, 0, 0, 0);
        checks++; if (resp_cycle != BEATS + 1) $display("[TB] FAIL b2b_wr2_latency: got %0d expected %0d", resp_cycle, BEATS + 1); else passed++;
        checks++; if (dfp_rdata !== model_rdata) $display("[TB] FAIL b2b_rdata_hold: got %h expected %h", dfp_rdata, model_rdata); else passed++;
    endtask

    task automatic test_random();
        logic [LINE_W-1:0] line;
        logic [31:0] addr;
        int op;
        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 2);
            addr = $urandom;
            line = rand_line();
            if (op == 0) begin
                run_read(addr, line, 1, $urandom_range(0, 3), -1);
                checks++; if (resp_seen !== 1'b1 || resp_gap != 1 || resp_after !== 1'b0)
                    $display("[TB] FAIL rand%0d_rd_resp: got seen=%b gap=%0d after=%b expected 1 1 0", n, resp_seen, resp_gap, resp_after); else passed++;
                checks++; if (cmd_addr !== line_base(addr) || saw_write !== 1'b0)
                    $display("[TB] FAIL rand%0d_rd_cmd: got %h wr=%b expected %h wr=0", n, cmd_addr, saw_write, line_base(addr)); else passed++;
                checks++; if (dfp_rdata !== line) $display("[TB] FAIL rand%0d_rd_data: got %h expected %h", n, dfp_rdata, line); else passed++;
                model_rdata = line;
            end else begin
                run_write(addr, line, op == 2, -1, 0, 1, 1);
                checks++; if (resp_seen !== 1'b1 || resp_gap != 1 || resp_after !== 1'b0 || saw_read !== 1'b0)
                    $display("[TB] FAIL rand%0d_wr_resp: got seen=%b gap=%0d after=%b rd=%b expected 1 1 0 0", n, resp_seen, resp_gap, resp_after, saw_read); else passed++;
                checks++; if (got_beats.size() != BEATS) $display("[TB] FAIL rand%0d_wr_count: got %0d expected %0d", n, got_beats.size(), BEATS); else passed++;
                for (int i = 0; i < BEATS && i < got_beats.size(); i++) begin
                    checks++;
                    if (got_beats[i] !== beat_of(line, i) || got_addrs[i] !== line_base(addr))
                        $display("[TB] FAIL rand%0d_wr_beat%0d: got %h@%h expected %h@%h", n, i, got_beats[i], got_addrs[i], beat_of(line, i), line_base(addr));
                    else passed++;
                end
                checks++; if (dfp_rdata !== model_rdata) $display("[TB] FAIL rand%0d_rdata_hold: got %h expected %h", n, dfp_rdata, model_rdata); else passed++;
            end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlap_cycles != 0) $display("[TB] FAIL rd_wr_overlap: got %0d cycles expected 0", overlap_cycles);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_directed();
        test_read_directed();
        test_write_stall();
        test_both_high();
        test_spurious_rvalid();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        test_exclusive();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001: Parameter LINE_W, default 256, SHALL be the cache line width in bits on the dfp side.
REQ-002: Parameter BEAT_W, default 64, SHALL be the burst beat width; BEATS = LINE_W/BEAT_W (4 at default).
REQ-003: Single clock, asynchronous active-low reset: clk  in  1  rising-edge clock for all state.
REQ-004: rst_n  in  1  asynchronous active-low reset.
REQ-005: dfp_addr  in  32  line request address from the cache; bits [4:0] ignored.
REQ-006: dfp_read  in  1  line read request, held until dfp_resp.
REQ-007: dfp_write  in  1  line write request, held until dfp_resp.
REQ-008: dfp_wdata  in  LINE_W  write line data, stable while dfp_write high.
REQ-009: dfp_rdata  out  LINE_W  assembled read line.
REQ-010: dfp_resp  out  1  one-cycle completion pulse.
REQ-011: bmem_addr  out  32  burst address, low 5 bits forced to 0.
REQ-012: bmem_read  out  1  read burst command.
REQ-013: bmem_write  out  1  write beat valid.
REQ-014: bmem_wdata  out  BEAT_W  write beat data.
REQ-015: bmem_ready  in  1  memory accepts command/beat this cycle.
REQ-016: bmem_rdata  in  BEAT_W  read beat data.
REQ-017: bmem_rvalid  in  1  read beat valid.

Function
REQ-018: FSM states SHALL be IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
REQ-019: IDLE: dfp_write high -> latch addr, wdata -> WR_DATA; else dfp_read high -> latch addr -> RD_CMD; write wins if both high.
REQ-020: Requests SHALL be sampled only in IDLE and in the cycle after RESP returns to IDLE; inputs outside IDLE ignored.
REQ-021: RD_CMD: bmem_read=1, bmem_addr=latched addr; on bmem_ready -> RD_DATA; no read command issued before this state.
REQ-022: RD_DATA: each bmem_rvalid cycle stores bmem_rdata into slice [k*BEAT_W +: BEAT_W], k = 2-bit beat counter starting at 0, then k++; after beat BEATS-1 -> RESP.
REQ-023: bmem_rvalid outside RD_DATA SHALL be ignored and not corrupt dfp_rdata.
REQ-024: WR_DATA: bmem_write=1, bmem_addr=latched addr for every beat, bmem_wdata = latched line slice k; k advances only when bmem_ready=1; after beat BEATS-1 accepted -> RESP.
REQ-025: bmem_ready low mid-burst SHALL hold bmem_write, bmem_wdata and k unchanged (stall, no beat skip/duplicate).
REQ-026: RESP: dfp_resp=1 for exactly one cycle, then IDLE; dfp_rdata holds last assembled line until next read completes.
REQ-027: bmem_read and bmem_write SHALL never be high in the same cycle.
REQ-028: Minimum latency: write = 1 (latch) + BEATS + 1 cycles with bmem_ready constant 1; read = 1 + 1 + (beats arrival) + 1.
REQ-029: Beat counter wraps 3->0 on the final beat; counter SHALL be 0 on every state entry.

Reset
REQ-030: rst_n low SHALL immediately (asynchronously) force state IDLE, k=0, dfp_resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, dfp_rdata=0.
REQ-031: Reset mid-burst SHALL abort the transaction without a dfp_resp; first request after rst_n rises is accepted on the following clock edge.

Verification
REQ-032: Write 0x...DDDD_CCCC_BBBB_AAAA line (beats 0xAAAA..., 0xBBBB..., 0xCCCC..., 0xDDDD...) to 0x0000_1020, bmem_ready=1 -> four bmem_write beats in order A,B,C,D at addr 0x0000_1020, dfp_resp 1 cycle after beat D.
REQ-033: Read 0x0000_1000 with beats 0x11,0x22,0x33,0x44 on rvalid (gaps allowed) -> dfp_rdata = {0x44,0x33,0x22,0x11} with dfp_resp one cycle after last beat.
REQ-034: Write with bmem_ready low for 3 cycles during beat 1 -> beat 1 held stable, exactly 4 beats accepted, no duplicates.
REQ-035: dfp_read and dfp_write high together with dfp_addr=0x0000_001F -> write burst at bmem_addr 0x0000_0000, no bmem_read.
REQ-036: rst_n pulsed low during read beat 2 -> outputs zero immediately, no dfp_resp; subsequent read completes correctly with k starting at 0.
REQ-037: Spurious bmem_rvalid in IDLE with data 0xFF -> dfp_rdata unchanged, no dfp_resp.
